// File: rtl/gray_to_binary_decoder.sv
// Sequential reflected-Gray to binary decoder with single-bit-step integrity check.
// Latency: result valid WIDTH-1 edges after accept (1 edge for WIDTH=1).
// Backpressure: result held in HOLD until out_ready; no new word accepted until then.
module gray_to_binary_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] G,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] B,
    output logic             step_err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] prev_g;
    logic             have_prev;
    logic             err_pend;
    logic             step_err_next;

    assign in_ready      = (state == IDLE);
    assign step_err_next = have_prev && ($countones(G ^ prev_g) != 1);

    // Resolve one bit per edge: each bit depends on the already-resolved bit above it.
    always_comb begin
        work_next = work;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (idx == IW'(i)) begin
                work_next[i] = work[i+1] ^ g_reg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            B         <= '0;
            step_err  <= 1'b0;
            have_prev <= 1'b0;
            prev_g    <= '0;
            g_reg     <= '0;
            work      <= '0;
            idx       <= '0;
            err_pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        g_reg     <= G;
                        work      <= G;
                        idx       <= IW'(WIDTH > 1 ? WIDTH - 2 : 0);
                        prev_g    <= G;
                        have_prev <= 1'b1;
                        err_pend  <= step_err_next;
                        if (WIDTH == 1) begin
                            B         <= G;
                            step_err  <= step_err_next;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    idx  <= idx - 1'b1;
                    if (idx == '0) begin
                        B         <= work_next;
                        step_err  <= err_pend;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Directed bench for gray_to_binary_decoder: WIDTH=4 main instance plus a WIDTH=1 instance.
module tb_gray_to_binary_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] G;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] B;
    logic       step_err;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] g1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] b1;
    logic       step_err1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gray_to_binary_decoder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .G(G),
        .out_valid(out_valid), .out_ready(out_ready), .B(B), .step_err(step_err)
    );

    gray_to_binary_decoder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .G(g1),
        .out_valid(out_valid1), .out_ready(out_ready1), .B(b1), .step_err(step_err1)
    );

    // Accept one word at the next edge, then count edges until out_valid (bounded).
    task automatic do_word(input logic [3:0] g, output logic [3:0] b, output logic e,
                           output int lat);
        in_valid = 1'b1;
        G        = g;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        b = B;
        e = step_err;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (B !== 4'b0000) begin n_err++; $display("FAIL reset_B got %b want 0000", B); end
        n_cmp++; if (step_err !== 1'b0) begin n_err++; $display("FAIL reset_step_err got %b want 0", step_err); end
        n_cmp++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || b1 !== 1'b0) begin
            n_err++; $display("FAIL reset_w1 got rdy=%b vld=%b b=%b want 1 0 0", in_ready1, out_valid1, b1);
        end
    endtask

    task automatic test_gray_sweep();
        logic [3:0] gray [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};
        logic [3:0] b;
        logic e;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_word(gray[i], b, e, lat);
            n_cmp++; if (b !== 4'(i)) begin n_err++; $display("FAIL sweep_B[%0d] got %b want %b", i, b, 4'(i)); end
            n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL sweep_err[%0d] got %b want 0", i, e); end
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL sweep_lat[%0d] got %0d want 3", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundary();
        logic [3:0] b;
        logic e;
        int lat;
        out_ready = 1'b1;
        // Previous word is 1000, so a repeat is distance 0 and 1111 is distance 3.
        do_word(4'b1000, b, e, lat);
        n_cmp++; if (b !== 4'b1111) begin n_err++; $display("FAIL bound_1000_B got %b want 1111", b); end
        n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL bound_1000_err got %b want 1", e); end
        @(posedge clk); #1;
        do_word(4'b1111, b, e, lat);
        n_cmp++; if (b !== 4'b1010) begin n_err++; $display("FAIL bound_1111_B got %b want 1010", b); end
        n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL bound_1111_err got %b want 1", e); end
        @(posedge clk); #1;
        in_valid1 = 1'b1;
        g1        = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL w1_out_valid got %b want 1", out_valid1); end
        n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL w1_B got %b want 1", b1); end
        n_cmp++; if (step_err1 !== 1'b0) begin n_err++; $display("FAIL w1_step_err got %b want 0", step_err1); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL w1_in_ready got %b want 1", in_ready1); end
    endtask

    task automatic test_backpressure();
        logic [3:0] b;
        logic e;
        int lat;
        out_ready = 1'b0;
        // Previous word 1111 -> 1110 is a legal single-bit step; binary 1011.
        do_word(4'b1110, b, e, lat);
        n_cmp++; if (b !== 4'b1011 || e !== 1'b0) begin n_err++; $display("FAIL bp_result got B=%b err=%b want 1011 0", b, e); end
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            G        = 4'(c * 3 + 1);
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_vld[%0d] got %b want 1", c, out_valid); end
            n_cmp++; if (B !== 4'b1011) begin n_err++; $display("FAIL bp_B[%0d] got %b want 1011", c, B); end
            n_cmp++; if (step_err !== 1'b0) begin n_err++; $display("FAIL bp_err[%0d] got %b want 0", c, step_err); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_rdy[%0d] got %b want 0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_rdy got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_vld got %b want 0", out_valid); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_no_second_word got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_step_errors();
        logic [3:0] gv [4] = '{4'b0000, 4'b0011, 4'b0011, 4'b0010};
        logic [3:0] bv [4] = '{4'b0000, 4'b0010, 4'b0010, 4'b0011};
        logic       ev [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] b;
        logic e;
        int lat;
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_word(gv[i], b, e, lat);
            n_cmp++; if (b !== bv[i]) begin n_err++; $display("FAIL step_B[%0d] got %b want %b", i, b, bv[i]); end
            n_cmp++; if (e !== ev[i]) begin n_err++; $display("FAIL step_err[%0d] got %b want %b", i, e, ev[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] b;
        logic e;
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        G         = 4'b1011;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_vld got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rdy got %b want 1", in_ready); end
        n_cmp++; if (B !== 4'b0000) begin n_err++; $display("FAIL mid_B got %b want 0000", B); end
        n_cmp++; if (step_err !== 1'b0) begin n_err++; $display("FAIL mid_err got %b want 0", step_err); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_discard got %b want 0", out_valid); end
        do_word(4'b0101, b, e, lat);
        n_cmp++; if (b !== 4'b0110) begin n_err++; $display("FAIL mid_after_B got %b want 0110", b); end
        n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL mid_after_err got %b want 0", e); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_trip();
        logic [3:0] b;
        logic [3:0] gw;
        logic e;
        int lat;
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            gw = 4'(v) ^ (4'(v) >> 1);
            do_word(gw, b, e, lat);
            n_cmp++; if (b !== 4'(v)) begin n_err++; $display("FAIL rt_B[%0d] got %b want %b", v, b, 4'(v)); end
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rt_lat[%0d] got %0d want 3", v, lat); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rt_once[%0d] got vld=%b want 0", v, out_valid); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        G          = 4'b0000;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        g1         = 1'b0;
        out_ready1 = 1'b1;
        test_reset();
        test_gray_sweep();
        test_boundary();
        test_backpressure();
        test_step_errors();
        test_reset_mid();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
